axil_slot_arbiter: RTL and testbench
====================================

// Module: axil_slot_arbiter
// PURPOSE
//  Sits between the HPS lightweight AXI master (AXI3, IDs, single beats) and N AXI-lite slave slots.
//  Decodes upper address bits, serialises traffic to one transaction at a time, and arbitrates read vs write.
//  Echoes IDs, generates RLAST, returns DECERR for unmapped slots and SLVERR on slave timeout.
// PARAMETERS
//  N_SLOTS      4     number of slave slots (power of 2, >=2); SEL_W=$clog2(N_SLOTS)
//  ADDR_W       21    address width; slot = addr[ADDR_W-1 -: SEL_W]
//  ID_W         12    AXI ID width
//  SLOT_EN      '1    N_SLOTS-bit mask; bit i=0 -> slot i unmapped (DECERR 2'b11)
//  TIMEOUT_CYC  1024  max cycles waiting on a slave (ready or response); 0 disables
// PORTS
//  clk                 in   1            clock
//  rst                 in   1            asynchronous, active-high reset
//  m_awid / m_arid     in   ID_W         master write / read ID
//  m_awaddr / m_araddr in   ADDR_W       master write / read address
//  m_awvalid/m_wvalid/m_arvalid  in 1    master request valids
//  m_awready/m_wready/m_arready  out 1   master request readies
//  m_wdata / m_wstrb   in   32 / 4       write data / strobes (m_wlast ignored)
//  m_bid / m_rid       out  ID_W         echoed IDs
//  m_bresp / m_rresp   out  2            responses
//  m_bvalid / m_rvalid out  1            response valids
//  m_bready / m_rready in   1            response readies
//  m_rdata             out  32           read data
//  m_rlast             out  1            = m_rvalid
//  s_awaddr / s_araddr out  ADDR_W       shared slave addresses (full address passed)
//  s_wdata / s_wstrb   out  32 / 4       shared slave write data / strobes
//  s_awvalid/s_wvalid/s_arvalid  out N_SLOTS  one-hot per-slot request valids
//  s_awready/s_wready/s_arready  in  N_SLOTS  per-slot readies
//  s_bvalid / s_rvalid in   N_SLOTS      per-slot response valids
//  s_bready / s_rready out  N_SLOTS      per-slot response readies
//  s_bresp / s_rresp   in   2*N_SLOTS    per-slot responses, slot i at [2i+1:2i]
//  s_rdata             in   32*N_SLOTS   per-slot read data, slot i at [32i+31:32i]
// BEHAVIOUR
//  Reset: state=IDLE; all valid/ready outputs 0; m_bresp/m_rresp/m_rdata/IDs 0; last_grant=WRITE (read wins first tie).
//  States: IDLE, W_FWD, W_RESP, W_OUT, R_FWD, R_RESP, R_OUT.
//  IDLE:
//   - write request = m_awvalid & m_wvalid; read request = m_arvalid.
//   - Both requests: grant the type not in last_grant (round-robin).
//   - m_awready=m_wready=1 together, combinationally, only in IDLE on a granted write; m_arready likewise.
//   - Accept captures addr/data/strb/ID/slot into registers.
//   - Unmapped slot -> W_OUT/R_OUT directly with resp=2'b11, rdata=0.
//  W_FWD:
//   - From cycle after accept, s_awvalid[slot] and s_wvalid[slot] held.
//   - Each drops independently after its own handshake; both done -> W_RESP.
//  W_RESP: s_bready[slot]=1; on s_bvalid[slot] capture bresp -> W_OUT.
//  W_OUT: m_bvalid=1, stable until m_bready -> IDLE. Read path mirrors (R_FWD/R_RESP/R_OUT, rdata captured).
//  Latency: mapped single write with zero-wait slave = accept + 3 cycles to m_bvalid; m_*valid registered.
//  Timeout: counter clears on entering *_FWD, counts in *_FWD/*_RESP.
//   - At TIMEOUT_CYC: drop slave valids/readies, resp=2'b10, rdata=0 -> *_OUT.
//   - A later stray slave response is not acknowledged.
//  Only one transaction outstanding; no master ready asserted outside IDLE.
//  Non-selected slots see valid/ready 0 at all times.
//  Reset mid-transaction returns to IDLE immediately; the in-flight response is lost.
// TESTING
//  - Write 0xDEADBEEF, strb 0xF, awid 0x123 to slot 1 (addr 0x080004), zero-wait slave
//    -> s_awvalid=4'b0010, m_bid=0x123, m_bresp=0, m_bvalid 3 cycles after accept.
//  - Read slot 2, arid 0x055, slave rdata 0xCAFEF00D after 5 wait cycles
//    -> m_rdata=0xCAFEF00D, m_rid=0x055, m_rlast=1 with m_rvalid.
//  - Write+read valid in same cycle after reset -> read granted first; next tie -> write granted.
//  - SLOT_EN=4'b0111, read slot 3 -> no s_arvalid pulse, m_rresp=2'b11, m_rdata=0.
//  - Slot 0 never asserts s_awready, TIMEOUT_CYC=16 -> m_bresp=2'b10 at 16 cycles; s_awvalid drops.
//  - Hold m_bready=0 for 10 cycles -> m_bvalid/m_bid/m_bresp stable, m_arready stays 0.
//  - Assert rst during R_RESP -> all outputs 0 next edge, then a fresh read completes normally.

Source files
------------

// File: rtl/axil_slot_arbiter.sv
// Single-outstanding AXI3-lite to N AXI-lite slot bridge.
// Round-robin read/write grant, ID echo, DECERR for unmapped slots, SLVERR on slave timeout.
module axil_slot_arbiter #(
   parameter int                 N_SLOTS     = 4,
   parameter int                 ADDR_W      = 21,
   parameter int                 ID_W        = 12,
   parameter logic [N_SLOTS-1:0] SLOT_EN     = '1,
   parameter int                 TIMEOUT_CYC = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ID_W-1:0]        m_awid,
   input  logic [ADDR_W-1:0]      m_awaddr,
   input  logic                   m_awvalid,
   output logic                   m_awready,
   input  logic [31:0]            m_wdata,
   input  logic [3:0]             m_wstrb,
   input  logic                   m_wvalid,
   output logic                   m_wready,
   output logic [ID_W-1:0]        m_bid,
   output logic [1:0]             m_bresp,
   output logic                   m_bvalid,
   input  logic                   m_bready,
   input  logic [ID_W-1:0]        m_arid,
   input  logic [ADDR_W-1:0]      m_araddr,
   input  logic                   m_arvalid,
   output logic                   m_arready,
   output logic [ID_W-1:0]        m_rid,
   output logic [31:0]            m_rdata,
   output logic [1:0]             m_rresp,
   output logic                   m_rvalid,
   output logic                   m_rlast,
   input  logic                   m_rready,
   output logic [ADDR_W-1:0]      s_awaddr,
   output logic [N_SLOTS-1:0]     s_awvalid,
   input  logic [N_SLOTS-1:0]     s_awready,
   output logic [31:0]            s_wdata,
   output logic [3:0]             s_wstrb,
   output logic [N_SLOTS-1:0]     s_wvalid,
   input  logic [N_SLOTS-1:0]     s_wready,
   input  logic [2*N_SLOTS-1:0]   s_bresp,
   input  logic [N_SLOTS-1:0]     s_bvalid,
   output logic [N_SLOTS-1:0]     s_bready,
   output logic [ADDR_W-1:0]      s_araddr,
   output logic [N_SLOTS-1:0]     s_arvalid,
   input  logic [N_SLOTS-1:0]     s_arready,
   input  logic [32*N_SLOTS-1:0]  s_rdata,
   input  logic [2*N_SLOTS-1:0]   s_rresp,
   input  logic [N_SLOTS-1:0]     s_rvalid,
   output logic [N_SLOTS-1:0]     s_rready
);

   localparam int SEL_W = $clog2(N_SLOTS);
   localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE, W_FWD, W_RESP, W_OUT, R_FWD, R_RESP, R_OUT
   } state_t;

   state_t              r_state;
   logic                r_last_rd;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [3:0]          r_wstrb;
   logic [ID_W-1:0]     r_id;
   logic [SEL_W-1:0]    r_slot;
   logic                r_aw_pend;
   logic                r_w_pend;
   logic                r_ar_pend;
   logic [TMO_W-1:0]    r_tmo;
   logic [1:0]          r_resp;
   logic [31:0]         r_rdata;
   logic                r_bvalid;
   logic                r_rvalid;

   logic                w_wreq, w_rreq, w_idle;
   logic                w_gnt_w, w_gnt_r;
   logic [SEL_W-1:0]    w_aw_slot, w_ar_slot;
   logic [N_SLOTS-1:0]  w_sel;
   logic                w_tmo;
   logic                w_awrdy, w_wrdy, w_ardy, w_bvld, w_rvld;
   logic                w_aw_done, w_w_done;
   logic [1:0]          w_bresp, w_rresp;
   logic [31:0]         w_rdata;

   assign w_wreq    = m_awvalid & m_wvalid;
   assign w_rreq    = m_arvalid;
   assign w_idle    = (r_state == IDLE) & ~rst;
   // r_last_rd=1 means the previous grant went to a read
   assign w_gnt_w   = w_idle & w_wreq & (~w_rreq | r_last_rd);
   assign w_gnt_r   = w_idle & w_rreq & (~w_wreq | ~r_last_rd);
   assign w_aw_slot = m_awaddr[ADDR_W-1 -: SEL_W];
   assign w_ar_slot = m_araddr[ADDR_W-1 -: SEL_W];
   assign w_sel     = {{(N_SLOTS-1){1'b0}}, 1'b1} << r_slot;
   assign w_tmo     = (TIMEOUT_CYC != 0) && (r_tmo == TMO_LAST);

   assign w_awrdy   = |(s_awready & w_sel);
   assign w_wrdy    = |(s_wready & w_sel);
   assign w_ardy    = |(s_arready & w_sel);
   assign w_bvld    = |(s_bvalid & w_sel);
   assign w_rvld    = |(s_rvalid & w_sel);
   assign w_aw_done = ~r_aw_pend | w_awrdy;
   assign w_w_done  = ~r_w_pend | w_wrdy;

   always_comb begin
      w_bresp = '0;
      w_rresp = '0;
      w_rdata = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (w_sel[i]) begin
            w_bresp = s_bresp[2*i +: 2];
            w_rresp = s_rresp[2*i +: 2];
            w_rdata = s_rdata[32*i +: 32];
         end
      end
   end

   assign m_awready = w_gnt_w;
   assign m_wready  = w_gnt_w;
   assign m_arready = w_gnt_r;
   assign m_bvalid  = r_bvalid;
   assign m_rvalid  = r_rvalid;
   assign m_rlast   = r_rvalid;
   assign m_bid     = r_id;
   assign m_rid     = r_id;
   assign m_bresp   = r_resp;
   assign m_rresp   = r_resp;
   assign m_rdata   = r_rdata;

   assign s_awaddr  = r_addr;
   assign s_araddr  = r_addr;
   assign s_wdata   = r_wdata;
   assign s_wstrb   = r_wstrb;
   assign s_awvalid = r_aw_pend ? w_sel : '0;
   assign s_wvalid  = r_w_pend ? w_sel : '0;
   assign s_arvalid = r_ar_pend ? w_sel : '0;
   assign s_bready  = (r_state == W_RESP) ? w_sel : '0;
   assign s_rready  = (r_state == R_RESP) ? w_sel : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_last_rd <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_id      <= '0;
         r_slot    <= '0;
         r_aw_pend <= 1'b0;
         r_w_pend  <= 1'b0;
         r_ar_pend <= 1'b0;
         r_tmo     <= '0;
         r_resp    <= '0;
         r_rdata   <= '0;
         r_bvalid  <= 1'b0;
         r_rvalid  <= 1'b0;
      end else begin
         r_tmo <= r_tmo + TMO_W'(1);
         unique case (r_state)
            IDLE: begin
               if (w_gnt_w) begin
                  r_last_rd <= 1'b0;
                  r_addr    <= m_awaddr;
                  r_wdata   <= m_wdata;
                  r_wstrb   <= m_wstrb;
                  r_id      <= m_awid;
                  r_slot    <= w_aw_slot;
                  r_tmo     <= '0;
                  if (SLOT_EN[w_aw_slot]) begin
                     r_aw_pend <= 1'b1;
                     r_w_pend  <= 1'b1;
                     r_state   <= W_FWD;
                  end else begin
                     r_resp   <= 2'b11;
                     r_bvalid <= 1'b1;
                     r_state  <= W_OUT;
                  end
               end else if (w_gnt_r) begin
                  r_last_rd <= 1'b1;
                  r_addr    <= m_araddr;
                  r_id      <= m_arid;
                  r_slot    <= w_ar_slot;
                  r_tmo     <= '0;
                  if (SLOT_EN[w_ar_slot]) begin
                     r_ar_pend <= 1'b1;
                     r_state   <= R_FWD;
                  end else begin
                     r_resp   <= 2'b11;
                     r_rdata  <= '0;
                     r_rvalid <= 1'b1;
                     r_state  <= R_OUT;
                  end
               end
            end
            W_FWD: begin
               if (w_tmo) begin
                  r_aw_pend <= 1'b0;
                  r_w_pend  <= 1'b0;
                  r_resp    <= 2'b10;
                  r_bvalid  <= 1'b1;
                  r_state   <= W_OUT;
               end else begin
                  if (w_awrdy) r_aw_pend <= 1'b0;
                  if (w_wrdy) r_w_pend <= 1'b0;
                  if (w_aw_done & w_w_done) r_state <= W_RESP;
               end
            end
            W_RESP: begin
               if (w_tmo) begin
                  r_resp   <= 2'b10;
                  r_bvalid <= 1'b1;
                  r_state  <= W_OUT;
               end else if (w_bvld) begin
                  r_resp   <= w_bresp;
                  r_bvalid <= 1'b1;
                  r_state  <= W_OUT;
               end
            end
            W_OUT: begin
               if (m_bready) begin
                  r_bvalid <= 1'b0;
                  r_state  <= IDLE;
               end
            end
            R_FWD: begin
               if (w_tmo) begin
                  r_ar_pend <= 1'b0;
                  r_resp    <= 2'b10;
                  r_rdata   <= '0;
                  r_rvalid  <= 1'b1;
                  r_state   <= R_OUT;
               end else if (w_ardy) begin
                  r_ar_pend <= 1'b0;
                  r_state   <= R_RESP;
               end
            end
            R_RESP: begin
               if (w_tmo) begin
                  r_resp   <= 2'b10;
                  r_rdata  <= '0;
                  r_rvalid <= 1'b1;
                  r_state  <= R_OUT;
               end else if (w_rvld) begin
                  r_resp   <= w_rresp;
                  r_rdata  <= w_rdata;
                  r_rvalid <= 1'b1;
                  r_state  <= R_OUT;
               end
            end
            R_OUT: begin
               if (m_rready) begin
                  r_rvalid <= 1'b0;
                  r_state  <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_slot_arbiter.sv
// Directed bench for axil_slot_arbiter: grant order, latency, DECERR, SLVERR timeout,
// response back-pressure and mid-transaction reset.
module tb_axil_slot_arbiter;

   localparam int N  = 4;
   localparam int AW = 21;
   localparam int IW = 12;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [IW-1:0]   m_awid, m_arid, m_bid, m_rid;
   logic [AW-1:0]   m_awaddr, m_araddr, s_awaddr, s_araddr;
   logic            m_awvalid, m_awready, m_wvalid, m_wready;
   logic [31:0]     m_wdata, m_rdata, s_wdata;
   logic [3:0]      m_wstrb, s_wstrb;
   logic [1:0]      m_bresp, m_rresp;
   logic            m_bvalid, m_bready, m_arvalid, m_arready;
   logic            m_rvalid, m_rlast, m_rready;
   logic [N-1:0]    s_awvalid, s_awready, s_wvalid, s_wready;
   logic [N-1:0]    s_bvalid, s_bready, s_arvalid, s_arready;
   logic [N-1:0]    s_rvalid, s_rready;
   logic [2*N-1:0]  s_bresp, s_rresp;
   logic [32*N-1:0] s_rdata;

   // simple shared slave model
   logic        tb_awready;
   int          tb_rwait;
   logic [31:0] tb_rdata;
   logic        r_sbv, r_rpend;
   int          r_rcnt;

   assign s_awready = {N{tb_awready}};
   assign s_wready  = '1;
   assign s_arready = '1;
   assign s_bvalid  = {N{r_sbv}};
   assign s_bresp   = '0;
   assign s_rvalid  = {N{r_rpend && (r_rcnt == 0)}};
   assign s_rresp   = '0;
   assign s_rdata   = {N{tb_rdata}};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sbv   <= 1'b0;
         r_rpend <= 1'b0;
         r_rcnt  <= 0;
      end else begin
         if (|(s_wvalid & s_wready)) r_sbv <= 1'b1;
         else if (|(s_bvalid & s_bready)) r_sbv <= 1'b0;
         if (|(s_arvalid & s_arready)) begin
            r_rpend <= 1'b1;
            r_rcnt  <= tb_rwait;
         end else if (r_rpend && r_rcnt != 0) r_rcnt <= r_rcnt - 1;
         else if (r_rpend && |s_rready) r_rpend <= 1'b0;
      end
   end

   axil_slot_arbiter #(
      .N_SLOTS(N), .ADDR_W(AW), .ID_W(IW),
      .SLOT_EN(4'b0111), .TIMEOUT_CYC(16)
   ) dut (
      .clk(clk), .rst(rst),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid),
      .m_rlast(m_rlast), .m_rready(m_rready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic w_start(input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [IW-1:0] id);
      m_awaddr = a; m_wdata = d; m_wstrb = s; m_awid = id;
      m_awvalid = 1'b1; m_wvalid = 1'b1;
   endtask

   task automatic r_start(input logic [AW-1:0] a, input logic [IW-1:0] id);
      m_araddr = a; m_arid = id; m_arvalid = 1'b1;
   endtask

   // returns on the negedge after the accepting posedge
   task automatic wait_aw(input string tag);
      int n;
      n = 0;
      #1;
      while (m_awready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk({tag, "_acc_to"}, 64'(n >= 100), 64'd0);
      @(negedge clk);
      m_awvalid = 1'b0; m_wvalid = 1'b0;
   endtask

   task automatic wait_ar(input string tag);
      int n;
      n = 0;
      #1;
      while (m_arready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk({tag, "_acc_to"}, 64'(n >= 100), 64'd0);
      @(negedge clk);
      m_arvalid = 1'b0;
   endtask

   // lat = cycles after the accepting edge until the response is visible
   task automatic wait_bv(input string tag, output int lat);
      lat = 1;
      while (m_bvalid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
      chk({tag, "_rsp_to"}, 64'(lat >= 100), 64'd0);
   endtask

   task automatic wait_rv(input string tag, output int lat);
      lat = 1;
      while (m_rvalid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
      chk({tag, "_rsp_to"}, 64'(lat >= 100), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int bad;
      int n;
      m_awid = '0; m_awaddr = '0; m_awvalid = 1'b0;
      m_wdata = '0; m_wstrb = '0; m_wvalid = 1'b0;
      m_arid = '0; m_araddr = '0; m_arvalid = 1'b0;
      m_bready = 1'b1; m_rready = 1'b1;
      tb_awready = 1'b1; tb_rwait = 0; tb_rdata = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_mvalid", 64'({m_bvalid, m_rvalid, m_rlast, m_awready, m_arready}), 64'd0);
      chk("rst_svalid", 64'({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}), 64'd0);
      chk("rst_regs", 64'({m_bid, m_rid, m_bresp, m_rresp, m_rdata}), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // simultaneous write+read: read first, then write, then read
      tb_rdata = 32'h0000_00B1;
      w_start(21'h080010, 32'h1111_2222, 4'hF, 12'h0A1);
      r_start(21'h000020, 12'h0B1);
      #1;
      chk("tie1_arready", 64'(m_arready), 64'd1);
      chk("tie1_awready", 64'(m_awready), 64'd0);
      wait_ar("tie1");
      wait_rv("tie1", lat);
      chk("tie1_rid", 64'(m_rid), 64'h0B1);
      chk("tie1_rdata", 64'(m_rdata), 64'h0B1);
      @(negedge clk);
      r_start(21'h100030, 12'h0B2);
      #1;
      chk("tie2_awready", 64'(m_awready), 64'd1);
      chk("tie2_arready", 64'(m_arready), 64'd0);
      wait_aw("tie2");
      chk("tie2_awvalid", 64'(s_awvalid), 64'b0010);
      wait_bv("tie2", lat);
      chk("tie2_bid", 64'(m_bid), 64'h0A1);
      @(negedge clk);
      chk("tie3_arready", 64'(m_arready), 64'd1);
      wait_ar("tie3");
      wait_rv("tie3", lat);
      chk("tie3_rid", 64'(m_rid), 64'h0B2);
      @(negedge clk);

      // mapped write to slot 1, zero-wait slave
      w_start(21'h080004, 32'hDEAD_BEEF, 4'hF, 12'h123);
      wait_aw("wr1");
      chk("wr1_awvalid", 64'(s_awvalid), 64'b0010);
      chk("wr1_wvalid", 64'(s_wvalid), 64'b0010);
      chk("wr1_awaddr", 64'(s_awaddr), 64'h080004);
      chk("wr1_wdata", 64'({s_wdata, s_wstrb}), 64'h0_DEAD_BEEF_F);
      wait_bv("wr1", lat);
      chk("wr1_lat", 64'(lat), 64'd3);
      chk("wr1_bid", 64'(m_bid), 64'h123);
      chk("wr1_bresp", 64'(m_bresp), 64'd0);
      @(negedge clk);
      chk("wr1_done", 64'(m_bvalid), 64'd0);

      // read slot 2 with 5 slave wait cycles
      tb_rwait = 5; tb_rdata = 32'hCAFE_F00D;
      r_start(21'h100000, 12'h055);
      wait_ar("rd2");
      chk("rd2_arvalid", 64'(s_arvalid), 64'b0100);
      wait_rv("rd2", lat);
      chk("rd2_lat", 64'(lat), 64'd8);
      chk("rd2_rdata", 64'(m_rdata), 64'hCAFE_F00D);
      chk("rd2_rid_resp_last", 64'({m_rid, m_rresp, m_rlast}), 64'({12'h055, 2'b00, 1'b1}));
      @(negedge clk);
      chk("rd2_done", 64'({m_rvalid, m_rlast}), 64'd0);

      // unmapped slot 3 returns DECERR without touching the slave
      tb_rwait = 0;
      r_start(21'h180008, 12'h0C3);
      wait_ar("rd3");
      chk("rd3_arvalid", 64'(s_arvalid), 64'd0);
      wait_rv("rd3", lat);
      chk("rd3_lat", 64'(lat), 64'd1);
      chk("rd3_resp", 64'({m_rresp, m_rlast, m_rid}), 64'({2'b11, 1'b1, 12'h0C3}));
      chk("rd3_rdata", 64'(m_rdata), 64'd0);
      @(negedge clk);

      // response back-pressure with a read waiting
      m_bready = 1'b0; tb_rdata = 32'h0BAD_0001;
      w_start(21'h000040, 32'h55AA_55AA, 4'h3, 12'h3C4);
      wait_aw("hold");
      r_start(21'h080000, 12'h0D1);
      wait_bv("hold", lat);
      chk("hold_lat", 64'(lat), 64'd3);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (m_bvalid !== 1'b1 || m_bid !== 12'h3C4 || m_bresp !== 2'b00 || m_arready !== 1'b0)
            bad++;
      end
      chk("hold_stable", 64'(bad), 64'd0);
      m_bready = 1'b1;
      @(negedge clk);
      chk("hold_release", 64'({m_bvalid, m_arready}), 64'b01);
      wait_ar("hold_rd");
      wait_rv("hold_rd", lat);
      chk("hold_rd_data", 64'({m_rid, m_rdata}), 64'({12'h0D1, 32'h0BAD_0001}));
      @(negedge clk);

      // reset while waiting on the read response
      tb_rwait = 5;
      r_start(21'h100000, 12'h0E5);
      wait_ar("rstx");
      @(negedge clk);
      chk("rstx_rready", 64'(s_rready), 64'b0100);
      rst = 1'b1;
      @(negedge clk);
      chk("rstx_outs", 64'({m_rvalid, m_rlast, s_rready, s_arvalid, m_arready, m_awready}), 64'd0);
      chk("rstx_regs", 64'({m_rid, m_rresp, m_rdata}), 64'd0);
      rst = 1'b0; tb_rwait = 0; tb_rdata = 32'h1234_5678;
      @(negedge clk);
      r_start(21'h080100, 12'h0F7);
      wait_ar("rstx_rd");
      wait_rv("rstx_rd", lat);
      chk("rstx_rd_lat", 64'(lat), 64'd3);
      chk("rstx_rd_data", 64'({m_rid, m_rresp, m_rdata}), 64'({12'h0F7, 2'b00, 32'h1234_5678}));
      @(negedge clk);

      // slot 0 never accepts the address: SLVERR after 16 cycles
      tb_awready = 1'b0;
      w_start(21'h000010, 32'hFEED_FACE, 4'hF, 12'h210);
      wait_aw("tmo");
      n = 0;
      while (s_awvalid === 4'b0001 && n < 100) begin n++; @(negedge clk); end
      chk("tmo_awcycles", 64'(n), 64'd16);
      chk("tmo_bresp", 64'({m_bvalid, m_bresp, m_bid}), 64'({1'b1, 2'b10, 12'h210}));
      chk("tmo_sdrop", 64'({s_awvalid, s_wvalid, s_bready}), 64'd0);
      @(negedge clk);
      chk("tmo_stray", 64'({s_bready, m_bvalid}), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
